// File: rtl/ext_int_ctrl.sv
// External (INT0/INT1) and pin-change (PCINT2) interrupt controller for Port D.
// Optional macro EXTINT_SYNC_EN inserts a two-flop pin synchronizer (prime limit 3 instead of 1).
module ext_int_ctrl #(
  parameter logic [5:0] EIFR_ADDR   = 6'h1C,
  parameter logic [5:0] EIMSK_ADDR  = 6'h1D,
  parameter logic [5:0] PCIFR_ADDR  = 6'h1B,
  parameter logic [7:0] PCICR_ADDR  = 8'h68,
  parameter logic [7:0] EICRA_ADDR  = 8'h69,
  parameter logic [7:0] PCMSK2_ADDR = 8'h6D
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic [5:0] IO_Addr,
  input  logic       iore,
  input  logic       iowe,
  input  logic [7:0] ramadr,
  input  logic       ramre,
  input  logic       ramwe,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       out_en,
  input  logic [7:0] pind_i,
  output logic       INT0_EN,
  output logic       INT1_EN,
  output logic       PCIE2,
  output logic [7:0] PCINT,
  output logic [2:0] irq,
  input  logic [2:0] irq_ack
);

`ifdef EXTINT_SYNC_EN
  localparam logic [1:0] PRIME_LIMIT = 2'd3;
`else
  localparam logic [1:0] PRIME_LIMIT = 2'd1;
`endif

  logic [3:0] r_eicra;
  logic [1:0] r_eimsk;
  logic [1:0] r_intf;
  logic       r_pcie2;
  logic       r_pcif2;
  logic [7:0] r_pcmsk2;
  logic [7:0] r_prev;
  logic [1:0] r_prime;

  logic [7:0] w_s;
  logic       w_io_eifr, w_io_eimsk, w_io_pcifr;
  logic       w_ext_pcicr, w_ext_eicra, w_ext_pcmsk2;
  logic [7:0] w_rd;
  logic       w_primed;
  logic [7:0] w_rise, w_fall, w_chg;
  logic [1:0] w_int_set, w_int_clr, w_intf_nxt;
  logic       w_pc_set, w_pc_clr, w_pcif2_nxt;

`ifdef EXTINT_SYNC_EN
  logic [7:0] r_sync1, r_sync2;

  // two-flop synchronizer on the raw pin levels
  always_ff @(posedge cp2) begin
    if (ireset) begin
      r_sync1 <= 8'h00;
      r_sync2 <= 8'h00;
    end else begin
      r_sync1 <= pind_i;
      r_sync2 <= r_sync1;
    end
  end
  assign w_s = r_sync2;
`else
  assign w_s = pind_i;
`endif

  assign w_io_eifr    = (IO_Addr == EIFR_ADDR);
  assign w_io_eimsk   = (IO_Addr == EIMSK_ADDR);
  assign w_io_pcifr   = (IO_Addr == PCIFR_ADDR);
  assign w_ext_pcicr  = (ramadr == PCICR_ADDR);
  assign w_ext_eicra  = (ramadr == EICRA_ADDR);
  assign w_ext_pcmsk2 = (ramadr == PCMSK2_ADDR);

  assign out_en = (iore & (w_io_eifr | w_io_eimsk | w_io_pcifr)) |
                  (ramre & (w_ext_pcicr | w_ext_eicra | w_ext_pcmsk2));

  // combinational read-data mux
  always_comb begin
    w_rd = 8'h00;
    if (iore & w_io_eifr) begin
      w_rd = {6'b000000, r_intf};
    end else if (iore & w_io_eimsk) begin
      w_rd = {6'b000000, r_eimsk};
    end else if (iore & w_io_pcifr) begin
      w_rd = {5'b00000, r_pcif2, 2'b00};
    end else if (ramre & w_ext_pcicr) begin
      w_rd = {5'b00000, r_pcie2, 2'b00};
    end else if (ramre & w_ext_eicra) begin
      w_rd = {4'b0000, r_eicra};
    end else if (ramre & w_ext_pcmsk2) begin
      w_rd = r_pcmsk2;
    end else begin
      w_rd = 8'h00;
    end
  end
  assign dbus_out = w_rd;

  function automatic logic edge_hit(input logic [1:0] isc, input logic rise, input logic fall);
    case (isc)
      2'b01:   edge_hit = rise | fall;
      2'b10:   edge_hit = fall;
      2'b11:   edge_hit = rise;
      default: edge_hit = 1'b0;
    endcase
  endfunction

  assign w_primed = (r_prime == PRIME_LIMIT);
  assign w_rise   = w_s & ~r_prev;
  assign w_fall   = ~w_s & r_prev;
  assign w_chg    = w_s ^ r_prev;

  assign w_int_set[0] = w_primed & edge_hit(r_eicra[1:0], w_rise[2], w_fall[2]);
  assign w_int_set[1] = w_primed & edge_hit(r_eicra[3:2], w_rise[3], w_fall[3]);
  // an ack only clears a flag whose vector is in an edge mode
  assign w_int_clr[0] = (iowe & w_io_eifr & dbus_in[0]) | (irq_ack[0] & (r_eicra[1:0] != 2'b00));
  assign w_int_clr[1] = (iowe & w_io_eifr & dbus_in[1]) | (irq_ack[1] & (r_eicra[3:2] != 2'b00));
  assign w_pc_set     = w_primed & (|(w_chg & r_pcmsk2));
  assign w_pc_clr     = (iowe & w_io_pcifr & dbus_in[2]) | irq_ack[2];

  // flag next-state: set has priority over clear
  always_comb begin
    w_intf_nxt  = r_intf;
    w_pcif2_nxt = r_pcif2;
    for (int n = 0; n < 2; n++) begin
      if (w_int_set[n]) begin
        w_intf_nxt[n] = 1'b1;
      end else if (w_int_clr[n]) begin
        w_intf_nxt[n] = 1'b0;
      end else begin
        w_intf_nxt[n] = r_intf[n];
      end
    end
    if (w_pc_set) begin
      w_pcif2_nxt = 1'b1;
    end else if (w_pc_clr) begin
      w_pcif2_nxt = 1'b0;
    end else begin
      w_pcif2_nxt = r_pcif2;
    end
  end

  // control registers, flags, previous sample and prime counter
  always_ff @(posedge cp2) begin
    if (ireset) begin
      r_eicra  <= 4'h0;
      r_eimsk  <= 2'b00;
      r_intf   <= 2'b00;
      r_pcie2  <= 1'b0;
      r_pcif2  <= 1'b0;
      r_pcmsk2 <= 8'h00;
      r_prev   <= 8'h00;
      r_prime  <= 2'd0;
    end else begin
      if (ramwe & w_ext_eicra)  r_eicra  <= dbus_in[3:0];
      if (iowe & w_io_eimsk)    r_eimsk  <= dbus_in[1:0];
      if (ramwe & w_ext_pcicr)  r_pcie2  <= dbus_in[2];
      if (ramwe & w_ext_pcmsk2) r_pcmsk2 <= dbus_in;
      r_intf  <= w_intf_nxt;
      r_pcif2 <= w_pcif2_nxt;
      r_prev  <= w_s;
      if (r_prime != PRIME_LIMIT) r_prime <= r_prime + 2'd1;
    end
  end

  // request outputs; level mode bypasses the flag
  always_comb begin
    irq = 3'b000;
    if (r_eicra[1:0] == 2'b00) begin
      irq[0] = ~w_s[2] & r_eimsk[0];
    end else begin
      irq[0] = r_intf[0] & r_eimsk[0];
    end
    if (r_eicra[3:2] == 2'b00) begin
      irq[1] = ~w_s[3] & r_eimsk[1];
    end else begin
      irq[1] = r_intf[1] & r_eimsk[1];
    end
    irq[2] = r_pcif2 & r_pcie2;
  end

  assign INT0_EN = r_eimsk[0];
  assign INT1_EN = r_eimsk[1];
  assign PCIE2   = r_pcie2;
  assign PCINT   = r_pcmsk2;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed bench for ext_int_ctrl: register table plus hand-written interrupt sequences.
module tb_ext_int_ctrl;

`ifdef EXTINT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       cp2 = 1'b0;
  logic       ireset;
  logic [5:0] IO_Addr;
  logic       iore, iowe;
  logic [7:0] ramadr;
  logic       ramre, ramwe;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       out_en;
  logic [7:0] pind_i;
  logic       INT0_EN, INT1_EN, PCIE2;
  logic [7:0] PCINT;
  logic [2:0] irq;
  logic [2:0] irq_ack;

  int n_err = 0;
  int n_chk = 0;

  ext_int_ctrl dut (
    .cp2(cp2), .ireset(ireset), .IO_Addr(IO_Addr), .iore(iore), .iowe(iowe),
    .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe), .dbus_in(dbus_in),
    .dbus_out(dbus_out), .out_en(out_en), .pind_i(pind_i),
    .INT0_EN(INT0_EN), .INT1_EN(INT1_EN), .PCIE2(PCIE2), .PCINT(PCINT),
    .irq(irq), .irq_ack(irq_ack)
  );

  always #5 cp2 = ~cp2;

  typedef struct {
    bit         ext;
    logic [7:0] addr;
    bit         wr;
    logic [7:0] wdata;
    logic [7:0] exp_d;
    bit         exp_oe;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge cp2);
      #1;
    end
  endtask

  task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
    IO_Addr = a; dbus_in = d; iowe = 1'b1;
    tick(1);
    iowe = 1'b0;
  endtask

  task automatic ext_wr(input logic [7:0] a, input logic [7:0] d);
    ramadr = a; dbus_in = d; ramwe = 1'b1;
    tick(1);
    ramwe = 1'b0;
  endtask

  task automatic rd_chk(input string name, input bit ext, input logic [7:0] a,
                        input logic [7:0] exp_d, input bit exp_oe);
    if (ext) begin
      ramadr = a; ramre = 1'b1;
    end else begin
      IO_Addr = a[5:0]; iore = 1'b1;
    end
    #1;
    check({name, "_data"}, {24'h0, dbus_out}, {24'h0, exp_d});
    check({name, "_oe"}, {31'h0, out_en}, {31'h0, exp_oe});
    ramre = 1'b0; iore = 1'b0;
  endtask

  task automatic irq_chk(input string name, input logic [2:0] exp);
    check(name, {29'h0, irq}, {29'h0, exp});
  endtask

  initial begin
    vt[0]  = '{1'b0, 8'h1C, 1'b0, 8'h00, 8'h00, 1'b1};
    vt[1]  = '{1'b0, 8'h1D, 1'b0, 8'h00, 8'h00, 1'b1};
    vt[2]  = '{1'b0, 8'h1B, 1'b0, 8'h00, 8'h00, 1'b1};
    vt[3]  = '{1'b1, 8'h68, 1'b0, 8'h00, 8'h00, 1'b1};
    vt[4]  = '{1'b1, 8'h69, 1'b0, 8'h00, 8'h00, 1'b1};
    vt[5]  = '{1'b1, 8'h6D, 1'b0, 8'h00, 8'h00, 1'b1};
    vt[6]  = '{1'b0, 8'h1E, 1'b0, 8'h00, 8'h00, 1'b0};
    vt[7]  = '{1'b1, 8'h6A, 1'b0, 8'h00, 8'h00, 1'b0};
    vt[8]  = '{1'b1, 8'h69, 1'b1, 8'hFF, 8'h0F, 1'b1};
    vt[9]  = '{1'b1, 8'h69, 1'b1, 8'h00, 8'h00, 1'b1};
    vt[10] = '{1'b0, 8'h1D, 1'b1, 8'hFF, 8'h03, 1'b1};
    vt[11] = '{1'b0, 8'h1D, 1'b1, 8'h00, 8'h00, 1'b1};
    vt[12] = '{1'b1, 8'h68, 1'b1, 8'hFF, 8'h04, 1'b1};
    vt[13] = '{1'b1, 8'h68, 1'b1, 8'h00, 8'h00, 1'b1};
    vt[14] = '{1'b1, 8'h6D, 1'b1, 8'hA5, 8'hA5, 1'b1};
    vt[15] = '{1'b1, 8'h6D, 1'b1, 8'h00, 8'h00, 1'b1};
    vt[16] = '{1'b0, 8'h1C, 1'b1, 8'hFF, 8'h00, 1'b1};
    vt[17] = '{1'b0, 8'h1B, 1'b1, 8'hFF, 8'h00, 1'b1};

    ireset = 1'b1; IO_Addr = 6'h00; iore = 1'b0; iowe = 1'b0;
    ramadr = 8'h00; ramre = 1'b0; ramwe = 1'b0; dbus_in = 8'h00;
    pind_i = 8'hFF; irq_ack = 3'b000;

    // reset with all pins high, then quiet release
    for (int i = 0; i < 3; i++) begin
      tick(1);
      irq_chk($sformatf("irq_in_reset%0d", i), 3'b000);
    end
    ireset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      irq_chk($sformatf("irq_after_reset%0d", i), 3'b000);
    end
    check("int_en_reset", {29'h0, INT0_EN, INT1_EN, PCIE2}, 32'h0);
    check("pcint_reset", {24'h0, PCINT}, 32'h0);

    // register table
    for (int i = 0; i < 18; i++) begin
      if (vt[i].wr) begin
        if (vt[i].ext) ext_wr(vt[i].addr, vt[i].wdata);
        else           io_wr(vt[i].addr[5:0], vt[i].wdata);
      end
      rd_chk($sformatf("vec%0d", i), vt[i].ext, vt[i].addr, vt[i].exp_d, vt[i].exp_oe);
    end

    pind_i = 8'h00;
    tick(4);

    // INT0 rising edge, then write-1 clear
    ext_wr(8'h69, 8'h03);
    io_wr(6'h1D, 8'h01);
    check("int0_en", {31'h0, INT0_EN}, 32'h1);
    pind_i = 8'h04;
    tick(LAT);
    irq_chk("int0_rise_early", 3'b000);
    tick(1);
    irq_chk("int0_rise_irq", 3'b001);
    rd_chk("int0_rise_eifr", 1'b0, 8'h1C, 8'h01, 1'b1);
    io_wr(6'h1C, 8'h01);
    irq_chk("int0_w1c_irq", 3'b000);
    rd_chk("int0_w1c_eifr", 1'b0, 8'h1C, 8'h00, 1'b1);

    // INT1 falling edge with mask off, then unmask
    pind_i = 8'h0C;
    tick(LAT + 2);
    ext_wr(8'h69, 8'h08);
    io_wr(6'h1D, 8'h00);
    pind_i = 8'h04;
    tick(LAT + 1);
    rd_chk("int1_fall_eifr", 1'b0, 8'h1C, 8'h02, 1'b1);
    irq_chk("int1_masked_irq", 3'b000);
    io_wr(6'h1D, 8'h02);
    irq_chk("int1_unmasked_irq", 3'b010);
    io_wr(6'h1C, 8'h02);
    irq_chk("int1_cleared_irq", 3'b000);

    // INT0 low-level mode
    ext_wr(8'h69, 8'h00);
    io_wr(6'h1D, 8'h01);
    pind_i = 8'h00;
    #1;
    tick(LAT);
    irq_chk("lvl_low_irq", 3'b001);
    rd_chk("lvl_eifr", 1'b0, 8'h1C, 8'h00, 1'b1);
    irq_ack = 3'b001;
    tick(1);
    irq_ack = 3'b000;
    irq_chk("lvl_ack_ignored", 3'b001);
    pind_i = 8'h04;
    #1;
    tick(LAT);
    irq_chk("lvl_high_irq", 3'b000);

    // PCINT2 masking, set-beats-ack, write-0 no effect
    ext_wr(8'h68, 8'h04);
    ext_wr(8'h6D, 8'h81);
    pind_i = 8'h14;
    tick(LAT + 1);
    rd_chk("pc_pd4_on", 1'b0, 8'h1B, 8'h00, 1'b1);
    pind_i = 8'h04;
    tick(LAT + 1);
    rd_chk("pc_pd4_off", 1'b0, 8'h1B, 8'h00, 1'b1);
    irq_chk("pc_pd4_irq", 3'b000);
    pind_i = 8'h84;
    tick(LAT);
    irq_chk("pc_pd7_early", 3'b000);
    tick(1);
    irq_chk("pc_pd7_irq", 3'b100);
    rd_chk("pc_pd7_pcifr", 1'b0, 8'h1B, 8'h04, 1'b1);
    pind_i = 8'h85;
    tick(LAT);
    irq_ack = 3'b100;
    tick(1);
    irq_ack = 3'b000;
    irq_chk("pc_set_wins_irq", 3'b100);
    rd_chk("pc_set_wins_pcifr", 1'b0, 8'h1B, 8'h04, 1'b1);
    irq_ack = 3'b100;
    tick(1);
    irq_ack = 3'b000;
    irq_chk("pc_ack_irq", 3'b000);
    rd_chk("pc_ack_pcifr", 1'b0, 8'h1B, 8'h00, 1'b1);
    pind_i = 8'h84;
    tick(LAT + 1);
    io_wr(6'h1B, 8'h00);
    rd_chk("pc_w0_pcifr", 1'b0, 8'h1B, 8'h04, 1'b1);
    io_wr(6'h1B, 8'h04);
    rd_chk("pc_w1c_pcifr", 1'b0, 8'h1B, 8'h00, 1'b1);

    // reset pulse with an edge in flight, then priming
    ext_wr(8'h69, 8'h01);
    pind_i = 8'h80;
    tick(LAT + 1);
    irq_chk("any_edge_irq", 3'b001);
    rd_chk("any_edge_eifr", 1'b0, 8'h1C, 8'h01, 1'b1);
    pind_i = 8'h04;
    tick(1);
    ireset = 1'b1;
    tick(1);
    ireset = 1'b0;
    irq_chk("rst_pulse_irq", 3'b000);
    rd_chk("rst_pulse_eifr", 1'b0, 8'h1C, 8'h00, 1'b1);
    rd_chk("rst_pulse_pcifr", 1'b0, 8'h1B, 8'h00, 1'b1);
    rd_chk("rst_pulse_eimsk", 1'b0, 8'h1D, 8'h00, 1'b1);
    ext_wr(8'h69, 8'h01);
    ext_wr(8'h6D, 8'hFF);
    tick(2);
    rd_chk("prime_eifr", 1'b0, 8'h1C, 8'h00, 1'b1);
    rd_chk("prime_pcifr", 1'b0, 8'h1B, 8'h00, 1'b1);
    ext_wr(8'h68, 8'h04);
    io_wr(6'h1D, 8'h01);
    pind_i = 8'h00;
    tick(LAT + 1);
    rd_chk("post_prime_eifr", 1'b0, 8'h1C, 8'h01, 1'b1);
    rd_chk("post_prime_pcifr", 1'b0, 8'h1B, 8'h04, 1'b1);
    irq_chk("post_prime_irq", 3'b101);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
